// File: rtl/axi_fft_window.sv
// axi_fft_window: SC16 window multiplier ahead of the FFT core.
// Coefficient RAM indexed by frame position, loaded via settings bus.
// Ports: clk, reset_n (async low), set_stb/set_addr/set_data,
//   i_tdata/i_tlast/i_tvalid/i_tready in, o_tdata/o_tlast/o_tvalid/
//   o_tready out; err_cnt when FFT_WINDOW_ERR_CNT_EN is defined.
module axi_fft_window #(
  parameter int MAX_FFT_SIZE_LOG2   = 11,
  parameter int SR_WINDOW_SIZE_LOG2 = 134,
  parameter int SR_WINDOW_LOAD      = 135,
  parameter int SR_WINDOW_EN        = 136
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
`ifdef FFT_WINDOW_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int         AW     = MAX_FFT_SIZE_LOG2;
  localparam logic [3:0] MAX_L  = 4'(MAX_FFT_SIZE_LOG2);
  localparam logic [7:0] A_SIZE = 8'(SR_WINDOW_SIZE_LOG2);
  localparam logic [7:0] A_LOAD = 8'(SR_WINDOW_LOAD);
  localparam logic [7:0] A_EN   = 8'(SR_WINDOW_EN);

  logic          en;
  logic          xfer;
  logic          wr_size;
  logic          wr_coef;
  logic          wr_en;
  logic [3:0]    size_log2;
  logic          window_en;
  logic [AW-1:0] idx;
  logic [AW-1:0] load_ptr;
  logic [AW-1:0] last_idx;
  logic          frame_end;

  logic signed [15:0] ram [2**AW];
  logic signed [15:0] s1_c;

  logic               s1_valid;
  logic               s1_last;
  logic               s1_win;
  logic [31:0]        s1_x;
  logic signed [15:0] s1_i;
  logic signed [15:0] s1_q;

  logic               s2_valid;
  logic               s2_last;
  logic               s2_win;
  logic [31:0]        s2_x;
  logic signed [31:0] s2_pi;
  logic signed [31:0] s2_pq;

  assign en       = ~o_tvalid | o_tready;
  assign i_tready = en;
  assign xfer     = i_tvalid & en;

  assign wr_size = set_stb & (set_addr == A_SIZE);
  assign wr_coef = set_stb & (set_addr == A_LOAD);
  assign wr_en   = set_stb & (set_addr == A_EN);

  assign last_idx  = ~({AW{1'b1}} << size_log2);
  assign frame_end = (idx == last_idx);

  assign s1_i = s1_x[31:16];
  assign s1_q = s1_x[15:0];

  // Q2.30 product -> Q1.15 with round-half-up and clip.
  function automatic logic [15:0] rnd(
    input logic signed [31:0] p
  );
    logic signed [32:0] s;
    s = (33'(p) + 33'sd16384) >>> 15;
    if (s > 33'sd32767)
      rnd = 16'h7fff;
    else if (s < -33'sd32768)
      rnd = 16'h8000;
    else
      rnd = s[15:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_log2 <= MAX_L;
      window_en <= 1'b0;
      load_ptr  <= '0;
      idx       <= '0;
    end else begin
      if (wr_size) begin
        size_log2 <= (set_data[3:0] > MAX_L) ?
                     MAX_L : set_data[3:0];
        load_ptr  <= '0;
        idx       <= '0;
      end else begin
        if (wr_coef)
          load_ptr <= load_ptr + 1'b1;
        if (xfer)
          idx <= (i_tlast | frame_end) ?
                 '0 : idx + 1'b1;
      end
      if (wr_en)
        window_en <= set_data[0];
    end
  end

  // Read-before-write: same-address collision returns old data.
  always_ff @(posedge clk) begin
    if (wr_coef)
      ram[load_ptr] <= set_data[15:0];
    if (en)
      s1_c <= ram[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_win   <= 1'b0;
      s1_x     <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_win   <= 1'b0;
      s2_x     <= '0;
      s2_pi    <= '0;
      s2_pq    <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (en) begin
      s1_valid <= i_tvalid;
      s1_last  <= i_tlast;
      s1_win   <= window_en;
      s1_x     <= i_tdata;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_win   <= s1_win;
      s2_x     <= s1_x;
      s2_pi    <= 32'(s1_i) * 32'(s1_c);
      s2_pq    <= 32'(s1_q) * 32'(s1_c);
      o_tvalid <= s2_valid;
      o_tlast  <= s2_last;
      o_tdata  <= s2_win ?
                  {rnd(s2_pi), rnd(s2_pq)} : s2_x;
    end
  end

`ifdef FFT_WINDOW_ERR_CNT_EN
  logic mismatch;
  assign mismatch = xfer & (i_tlast ^ frame_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_cnt <= '0;
    else if (wr_size)
      err_cnt <= '0;
    else if (mismatch && err_cnt != 16'hffff)
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_axi_fft_window.sv
// tb_axi_fft_window: directed bench for axi_fft_window.
// Hand-computed expectations; one summary line at the end.
module tb_axi_fft_window;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
`ifdef FFT_WINDOW_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [32:0] out_q[$];
  int          out_cyc[$];
  int          in_cyc[$];

  axi_fft_window dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
`ifdef FFT_WINDOW_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_tvalid && o_tready) begin
      out_q.push_back({o_tlast, o_tdata});
      out_cyc.push_back(cyc);
    end
    if (i_tvalid && i_tready)
      in_cyc.push_back(cyc);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    @(posedge clk);
    #1;
    set_stb  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d,
                      input logic l);
    bit done;
    done     = 1'b0;
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (i_tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
    if (!done) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_n(input int n);
    for (int t = 0; t < 300 && out_q.size() < n; t++)
      @(posedge clk);
    #1;
    chk("out_count", 64'(out_q.size()), 64'(n));
  endtask

  task automatic clr();
    out_q.delete();
    out_cyc.delete();
    in_cyc.delete();
  endtask

  logic [32:0] exp_q[$];

  initial begin
    reset_n  = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_tvalid), 64'(0));
    chk("rst_data", 64'(o_tdata), 64'(0));
    chk("rst_last", 64'(o_tlast), 64'(0));
    chk("rst_ready", 64'(i_tready), 64'(1));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: half-scale window over an 8-sample frame
    wr(8'd134, 32'd3);
    for (int k = 0; k < 8; k++) wr(8'd135, 32'h4000);
    wr(8'd136, 32'd1);
    clr();
    for (int k = 0; k < 8; k++)
      send({16'd1000, 16'd1000}, k == 7);
    wait_n(8);
    for (int k = 0; k < 8; k++)
      chk("t1_out", 64'(out_q[k]),
          64'({k == 7, 32'h01f4_01f4}));
    chk("t1_latency", 64'(out_cyc[0] - in_cyc[0]), 64'(3));

    // 2: bypass keeps data untouched
    wr(8'd136, 32'd0);
    clr();
    send(32'h7fff_8000, 1'b0);
    wait_n(1);
    chk("t2_bypass", 64'(out_q[0]), 64'({1'b0, 32'h7fff_8000}));
    chk("t2_latency", 64'(out_cyc[0] - in_cyc[0]), 64'(3));

    // 3: saturation with c = -1.0 on RAM[0]
    wr(8'd134, 32'd0);
    wr(8'd135, 32'h8000);
    wr(8'd136, 32'd1);
    clr();
    send(32'h8000_4000, 1'b1);
    wait_n(1);
    chk("t3_sat", 64'(out_q[0]), 64'({1'b1, 32'h7fff_c000}));

    // 4: backpressure mid-stream, bypass mode
    wr(8'd136, 32'd0);
    clr();
    fork
      begin
        for (int i = 0; i < 16; i++)
          send({16'(i * 3 + 1), 16'(i * 5 + 2)}, i == 15);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        o_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t4_stall_rdy", 64'(i_tready), 64'(0));
          @(posedge clk);
          #1;
        end
        o_tready = 1'b1;
      end
    join
    wait_n(16);
    for (int i = 0; i < 16; i++)
      chk("t4_order", 64'(out_q[i]),
          64'({i == 15, 16'(i * 3 + 1), 16'(i * 5 + 2)}));

    // 5: short frame then full frame, ramp coefficients
    wr(8'd134, 32'd3);
    for (int k = 0; k < 8; k++)
      wr(8'd135, 32'((k + 1) * 2048));
    wr(8'd136, 32'd1);
    clr();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      send(32'h1000_1000, k == 4);
      exp_q.push_back({k == 4, 16'(256 * (k + 1)),
                       16'(256 * (k + 1))});
    end
    for (int k = 0; k < 8; k++) begin
      send(32'h1000_1000, k == 7);
      exp_q.push_back({k == 7, 16'(256 * (k + 1)),
                       16'(256 * (k + 1))});
    end
    wait_n(13);
    for (int k = 0; k < 13; k++)
      chk("t5_frames", 64'(out_q[k]), 64'(exp_q[k]));
`ifdef FFT_WINDOW_ERR_CNT_EN
    chk("t5_err_cnt", 64'(err_cnt), 64'(1));
`endif

    // 6: reset with two samples in flight
    clr();
    send(32'h1111_2222, 1'b0);
    send(32'h3333_4444, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_valid_now", 64'(o_tvalid), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_out", 64'(out_q.size()), 64'(0));
    chk("t6_valid_idle", 64'(o_tvalid), 64'(0));
    send(32'h5555_6666, 1'b0);
    wait_n(1);
    chk("t6_after", 64'(out_q[0]), 64'({1'b0, 32'h5555_6666}));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
